// File: rtl/cache_set_tags_if.sv
// Request/response bundle between the cache controller and the set tag store.
// The controller holds the master modport and the tag store holds the slave modport.
interface cache_set_tags_if #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned TAG_W = 19
);
   localparam int unsigned WayW = $clog2(WAYS);

   logic             req_valid;
   logic [1:0]       req_op;
   logic [TAG_W-1:0] req_tag;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [WayW-1:0]  rsp_way;
   logic             rsp_evict;
   logic             rsp_evict_dirty;
   logic [TAG_W-1:0] rsp_evict_tag;

   modport master (
      output req_valid, req_op, req_tag,
      input  rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_dirty, rsp_evict_tag
   );

   modport slave (
      input  req_valid, req_op, req_tag,
      output rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_dirty, rsp_evict_tag
   );
endinterface

// File: rtl/cache_set_tags.sv
// Tag/metadata store for one N-way set: tag compare, true-LRU victim choice and
// a registered one-cycle response carrying the hit or allocated way and eviction info.
module cache_set_tags #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned TAG_W = 19
) (
   input  logic            clk,
   input  logic            rst,
   cache_set_tags_if.slave bus,
   output logic [WAYS-1:0] valid_vec,
   output logic [WAYS-1:0] dirty_vec
);
   localparam int unsigned WayW = $clog2(WAYS);

   typedef enum logic [1:0] {OpRead = 2'b00, OpWrite = 2'b01, OpInval = 2'b10, OpClean = 2'b11} op_e;

   logic [WAYS-1:0]  valid_q, valid_d;
   logic [WAYS-1:0]  dirty_q, dirty_d;
   logic [TAG_W-1:0] tag_q [WAYS];
   logic [TAG_W-1:0] tag_d [WAYS];
   logic [WayW-1:0]  age_q [WAYS];
   logic [WayW-1:0]  age_d [WAYS];

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_hit_q, rsp_hit_d;
   logic [WayW-1:0]  rsp_way_q, rsp_way_d;
   logic             rsp_evict_q, rsp_evict_d;
   logic             rsp_evict_dirty_q, rsp_evict_dirty_d;
   logic [TAG_W-1:0] rsp_evict_tag_q, rsp_evict_tag_d;

   logic             hit_any;
   logic [WayW-1:0]  hit_way;
   logic             found_inv;
   logic [WayW-1:0]  victim;
   logic             do_touch;
   logic [WayW-1:0]  touch_way;

   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (valid_q[i] && (tag_q[i] == bus.req_tag)) begin
            hit_any = 1'b1;
            hit_way = WayW'(i);
         end
      end
   end

   // Empty ways fill lowest-index first; only a full set falls back to the LRU way.
   always_comb begin
      found_inv = 1'b0;
      victim    = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (!found_inv && !valid_q[i]) begin
            found_inv = 1'b1;
            victim    = WayW'(i);
         end
      end
      if (!found_inv) begin
         for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == WayW'(WAYS - 1)) begin
               victim = WayW'(i);
            end
         end
      end
   end

   always_comb begin
      valid_d           = valid_q;
      dirty_d           = dirty_q;
      tag_d             = tag_q;
      age_d             = age_q;
      rsp_valid_d       = 1'b0;
      rsp_hit_d         = 1'b0;
      rsp_way_d         = '0;
      rsp_evict_d       = 1'b0;
      rsp_evict_dirty_d = 1'b0;
      rsp_evict_tag_d   = '0;
      do_touch          = 1'b0;
      touch_way         = '0;

      if (bus.req_valid) begin
         rsp_valid_d = 1'b1;
         unique case (op_e'(bus.req_op))
            OpRead, OpWrite: begin
               do_touch = 1'b1;
               if (hit_any) begin
                  rsp_hit_d = 1'b1;
                  rsp_way_d = hit_way;
                  touch_way = hit_way;
                  if (op_e'(bus.req_op) == OpWrite) begin
                     dirty_d[hit_way] = 1'b1;
                  end
               end else begin
                  rsp_way_d       = victim;
                  touch_way       = victim;
                  rsp_evict_d     = valid_q[victim];
                  if (valid_q[victim]) begin
                     rsp_evict_dirty_d = dirty_q[victim];
                     rsp_evict_tag_d   = tag_q[victim];
                  end
                  valid_d[victim] = 1'b1;
                  dirty_d[victim] = (op_e'(bus.req_op) == OpWrite);
                  tag_d[victim]   = bus.req_tag;
               end
            end
            OpInval: begin
               if (hit_any) begin
                  rsp_hit_d         = 1'b1;
                  rsp_way_d         = hit_way;
                  rsp_evict_d       = 1'b1;
                  rsp_evict_dirty_d = dirty_q[hit_way];
                  rsp_evict_tag_d   = tag_q[hit_way];
                  valid_d[hit_way]  = 1'b0;
                  dirty_d[hit_way]  = 1'b0;
                  // Close the gap left behind so ages remain a permutation.
                  for (int j = 0; j < WAYS; j++) begin
                     if (age_q[j] > age_q[hit_way]) begin
                        age_d[j] = age_q[j] - WayW'(1);
                     end
                  end
                  age_d[hit_way] = WayW'(WAYS - 1);
               end
            end
            OpClean: begin
               if (hit_any) begin
                  rsp_hit_d         = 1'b1;
                  rsp_way_d         = hit_way;
                  rsp_evict_dirty_d = dirty_q[hit_way];
                  dirty_d[hit_way]  = 1'b0;
               end
            end
            default: ;
         endcase
      end

      if (do_touch) begin
         for (int j = 0; j < WAYS; j++) begin
            if (age_q[j] < age_q[touch_way]) begin
               age_d[j] = age_q[j] + WayW'(1);
            end
         end
         age_d[touch_way] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q           <= '0;
         dirty_q           <= '0;
         for (int i = 0; i < WAYS; i++) begin
            tag_q[i] <= '0;
            age_q[i] <= WayW'(i);
         end
         rsp_valid_q       <= 1'b0;
         rsp_hit_q         <= 1'b0;
         rsp_way_q         <= '0;
         rsp_evict_q       <= 1'b0;
         rsp_evict_dirty_q <= 1'b0;
         rsp_evict_tag_q   <= '0;
      end else begin
         valid_q           <= valid_d;
         dirty_q           <= dirty_d;
         tag_q             <= tag_d;
         age_q             <= age_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_hit_q         <= rsp_hit_d;
         rsp_way_q         <= rsp_way_d;
         rsp_evict_q       <= rsp_evict_d;
         rsp_evict_dirty_q <= rsp_evict_dirty_d;
         rsp_evict_tag_q   <= rsp_evict_tag_d;
      end
   end

   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_hit         = rsp_hit_q;
   assign bus.rsp_way         = rsp_way_q;
   assign bus.rsp_evict       = rsp_evict_q;
   assign bus.rsp_evict_dirty = rsp_evict_dirty_q;
   assign bus.rsp_evict_tag   = rsp_evict_tag_q;
   assign valid_vec           = valid_q;
   assign dirty_vec           = dirty_q;
endmodule

// File: doc/cache_set_tags.md
# cache_set_tags

Tag/metadata store for one N-way set-associative cache set, successor to the single-line block. It holds WAYS entries of {valid, dirty, tag}. Each cycle it accepts one command (read, write, invalidate, clean) and performs tag compare, hit/miss resolution and true-LRU victim selection. It returns a registered response with the hit way and any eviction information. It sits between the cache controller FSM and the data array, which is indexed by the returned way.

## Interface
Parameters:
- WAYS, 4, number of ways; power of two, ≥2
- TAG_W, 19, tag width in bits

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  command present this cycle
- req_op  in  2  00 read, 01 write, 10 invalidate, 11 clean
- req_tag  in  TAG_W  tag to look up
- rsp_valid  out  1  response valid; req_valid delayed 1 cycle
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  log2(WAYS)  hit way, or allocated way on read/write miss
- rsp_evict  out  1  a valid line was displaced or invalidated
- rsp_evict_dirty  out  1  displaced/invalidated line was dirty (write-back needed)
- rsp_evict_tag  out  TAG_W  tag of displaced/invalidated line
- valid_vec  out  WAYS  current valid bits
- dirty_vec  out  WAYS  current dirty bits

## Operation
- Per-way state: valid, dirty, tag[TAG_W], age[log2(WAYS)]. Ages always form a permutation of 0..WAYS-1. Age 0 is MRU; age WAYS-1 is LRU.
- Reset: valid=0, dirty=0, tag=0, age[i]=i for every way; all rsp_* outputs 0.
- Lookup is combinational on the current registers: hit = any way with valid && tag==req_tag. At most one way can hit; the block itself never installs a duplicate.
- Touch(w): every way with age < age[w] increments its age; age[w] is set to 0. Other ages are unchanged.
- Read hit: touch(hit way). No other state changes.
- Write hit: touch(hit way) and set dirty=1.
- Read/write miss: select victim = lowest-index invalid way; if all ways are valid, select the way with age WAYS-1. Install tag, set valid=1, set dirty=(op==write), then touch(victim). rsp_evict = victim was valid. rsp_evict_dirty and rsp_evict_tag report the victim's old dirty bit and tag.
- Invalidate hit: set valid=0 and dirty=0, and set that way's age to WAYS-1. Ways whose age was greater than the old age decrement by 1, so ages stay a permutation. rsp_evict=1, rsp_evict_dirty=old dirty, rsp_evict_tag=old tag.
- Invalidate miss: no state change; rsp_evict=0.
- Clean hit: set dirty=0, ages unchanged, rsp_evict=0, rsp_evict_dirty=old dirty. Clean miss: no state change.
- When rsp_evict=0, rsp_evict_tag holds 0. When the operation is a miss with no allocation, rsp_way holds 0.
- req_valid=0: no state change; rsp_valid=0 next cycle and all other rsp_* are driven 0.

## Timing
- Latency is 1 cycle: the request in cycle n produces rsp_* in cycle n+1. The state update commits at the same edge.
- Throughput is one command per cycle. There is no backpressure and no ready signal.
- Back-to-back commands: the request in cycle n+1 sees the state written by the request in cycle n, with no hazard window. A miss on tag T followed immediately by a read of T hits.
- valid_vec and dirty_vec reflect the registered state. They change the cycle after the command that modifies them.
- rst asserted with req_valid=1: reset wins. The request is dropped and no response is produced in the following cycle (rsp_valid=0).
- rst mid-stream: all state returns to reset values at that edge. The first command after rst deasserts sees an empty set.

## Test plan
- Cold fill, WAYS=4: read tags 0x10,0x11,0x12,0x13 → misses allocated to ways 0,1,2,3, rsp_evict=0. Then read 0x10 → hit on way 0, latency 1 cycle.
- LRU eviction: after the fill, read 0x10, then read 0x14 → miss, victim way 1 (tag 0x11), rsp_evict=1, rsp_evict_dirty=0, rsp_evict_tag=0x11.
- Dirty write-back: write 0x20 on a miss (dirty=1), fill 3 other tags, then access 3 new tags → the eviction of 0x20 reports rsp_evict_dirty=1 and rsp_evict_tag=0x20.
- Invalidate/clean: write 0x30 then invalidate 0x30 → rsp_evict=1, rsp_evict_dirty=1, valid_vec bit cleared. The next miss reuses that way ahead of the LRU way. Clean on a dirty hit → dirty_vec bit clears and valid stays set.
- Back-to-back and reset: in consecutive cycles send miss 0x40 then read 0x40 → second response hits. Assert rst together with req_valid → rsp_valid=0 next cycle, valid_vec=0, ages restored to age[i]=i.
- Random stress against a reference model (WAYS=2,4,8): ages remain a permutation every cycle and at most one way ever matches a given tag.
